// File: rtl/sm_add_arbiter.sv
// Round-robin sequencer sharing one sign-magnitude adder among four requesters.
// Operands are held on the adder for ADD_LAT cycles, then the result is returned tagged with its owner.
module sm_add_arbiter #(
  parameter int ADD_LAT = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  req_valid_i,
  input  logic [19:0] req_a_i,
  input  logic [19:0] req_b_i,
  output logic [3:0]  req_ready_o,
  output logic [4:0]  add_a_o,
  output logic [4:0]  add_b_o,
  output logic        add_go_o,
  input  logic [5:0]  add_c_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [5:0]  res_c_o,
  output logic [1:0]  res_id_o,
  output logic        busy_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [3:0] LatInit = 4'(ADD_LAT);

  if (ADD_LAT < 1 || ADD_LAT > 15) begin : gBadLat
    $error("sm_add_arbiter: ADD_LAT must be in 1..15");
  end

  logic [1:0] state_q, state_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] op_id_q, op_id_d;
  logic [4:0] add_a_q, add_a_d;
  logic [4:0] add_b_q, add_b_d;
  logic       add_go_q, add_go_d;
  logic       res_valid_q, res_valid_d;
  logic [5:0] res_c_q, res_c_d;
  logic [1:0] res_id_q, res_id_d;

  logic [1:0] grantIdx;
  logic       grantHit;
  logic [1:0] scanIdx;

  // First valid requester at or after the round-robin pointer wins.
  always_comb begin
    grantIdx = 2'd0;
    grantHit = 1'b0;
    scanIdx  = 2'd0;
    for (int k = 0; k < 4; k++) begin
      scanIdx = rr_ptr_q + 2'(k);
      if (!grantHit && req_valid_i[scanIdx]) begin
        grantIdx = scanIdx;
        grantHit = 1'b1;
      end
    end
  end

  assign req_ready_o = (state_q == S_IDLE && grantHit && !rst_i) ? (4'b0001 << grantIdx) : 4'b0000;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    op_id_d     = op_id_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_go_d    = 1'b0;
    res_valid_d = res_valid_q;
    res_c_d     = res_c_q;
    res_id_d    = res_id_q;
    case (state_q)
      S_IDLE: begin
        if (grantHit) begin
          add_a_d  = req_a_i[5*grantIdx +: 5];
          add_b_d  = req_b_i[5*grantIdx +: 5];
          op_id_d  = grantIdx;
          cnt_d    = LatInit;
          rr_ptr_d = grantIdx + 2'd1;
          add_go_d = 1'b1;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          res_c_d     = add_c_i;
          res_id_d    = op_id_q;
          res_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset discards any in-flight operation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= 2'd0;
      cnt_q       <= 4'd0;
      op_id_q     <= 2'd0;
      add_a_q     <= 5'd0;
      add_b_q     <= 5'd0;
      add_go_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_c_q     <= 6'd0;
      res_id_q    <= 2'd0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      op_id_q     <= op_id_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_go_q    <= add_go_d;
      res_valid_q <= res_valid_d;
      res_c_q     <= res_c_d;
      res_id_q    <= res_id_d;
    end
  end

  assign add_a_o     = add_a_q;
  assign add_b_o     = add_b_q;
  assign add_go_o    = add_go_q;
  assign res_valid_o = res_valid_q;
  assign res_c_o     = res_c_q;
  assign res_id_o    = res_id_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sm_add_arbiter.sv
// Self-checking bench for sm_add_arbiter: vector table, hand sequences and random traffic
// against a phase-counting reference model; a second instance covers ADD_LAT=1.
module tb_sm_add_arbiter;

  localparam int Lat = 2;

  logic        clk;
  logic        rst;
  logic [3:0]  reqValid;
  logic [19:0] reqA, reqB;
  logic [3:0]  reqReady;
  logic [4:0]  addA, addB;
  logic        addGo;
  logic [5:0]  addC;
  logic        resValid, resReady;
  logic [5:0]  resC;
  logic [1:0]  resId;
  logic        busy;

  logic        rst1;
  logic [3:0]  reqValid1;
  logic [19:0] reqA1, reqB1;
  logic [3:0]  reqReady1;
  logic [4:0]  addA1, addB1;
  logic        addGo1;
  logic [5:0]  addC1;
  logic        resValid1, resReady1;
  logic [5:0]  resC1;
  logic [1:0]  resId1;
  logic        busy1;

  int nChecks = 0;
  int nPass = 0;

  // Reference model: phase 0 idle, 1..Lat adding, Lat+1 holding the result
  int         mPhase;
  int         mPtr;
  logic [4:0] mA, mB;
  int         mOpId;
  logic [5:0] mResC;
  logic [1:0] mResId;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [19:0] a;
    logic [19:0] b;
    logic        rr;
    logic [3:0]  expReady;
    logic        expGo;
    logic        expBusy;
    logic        expResValid;
    logic [5:0]  expResC;
    logic [1:0]  expResId;
  } vec_t;

  vec_t tbl[6];

  sm_add_arbiter #(.ADD_LAT(Lat)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(reqValid), .req_a_i(reqA), .req_b_i(reqB),
    .req_ready_o(reqReady), .add_a_o(addA), .add_b_o(addB), .add_go_o(addGo), .add_c_i(addC),
    .res_valid_o(resValid), .res_ready_i(resReady), .res_c_o(resC), .res_id_o(resId), .busy_o(busy)
  );

  sm_add_arbiter #(.ADD_LAT(1)) dut1 (
    .clk_i(clk), .rst_i(rst1), .req_valid_i(reqValid1), .req_a_i(reqA1), .req_b_i(reqB1),
    .req_ready_o(reqReady1), .add_a_o(addA1), .add_b_o(addB1), .add_go_o(addGo1), .add_c_i(addC1),
    .res_valid_o(resValid1), .res_ready_i(resReady1), .res_c_o(resC1), .res_id_o(resId1), .busy_o(busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [5:0] sumOf(input logic [4:0] a, input logic [4:0] b);
    return {1'b0, {1'b0, a[3:0]} + {1'b0, b[3:0]}};
  endfunction

  // Adder stub: garbage in the first operand cycle, sum afterwards
  assign addC = addGo ? 6'h2A : sumOf(addA, addB);

  function automatic int findGrant(input logic [3:0] v, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (v[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic int oneHotIdx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v == (4'b0001 << i)) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] v, input logic [19:0] a,
                               input logic [19:0] b, input logic rr);
    rst = r;
    reqValid = v;
    reqA = a;
    reqB = b;
    resReady = rr;
    @(negedge clk);
  endtask

  task automatic checkOutput();
    int g;
    logic [3:0] expReady;
    g = findGrant(reqValid, mPtr);
    expReady = (!rst && mPhase == 0 && g >= 0) ? (4'b0001 << g) : 4'b0000;
    chk("req_ready", 32'(reqReady), 32'(expReady));
    chk("busy", 32'(busy), 32'(mPhase != 0));
    chk("add_go", 32'(addGo), 32'(mPhase == 1));
    chk("add_a", 32'(addA), 32'(mA));
    chk("add_b", 32'(addB), 32'(mB));
    chk("res_valid", 32'(resValid), 32'(mPhase == Lat + 1));
    chk("res_c", 32'(resC), 32'(mResC));
    chk("res_id", 32'(resId), 32'(mResId));
  endtask

  task automatic modelReset();
    mPhase = 0; mPtr = 0; mA = '0; mB = '0; mOpId = 0; mResC = '0; mResId = '0;
  endtask

  // Update the model from the inputs in force this cycle, then cross the edge
  task automatic advance();
    int g;
    if (rst) modelReset();
    else if (mPhase == 0) begin
      g = findGrant(reqValid, mPtr);
      if (g >= 0) begin
        mA = reqA[5*g +: 5];
        mB = reqB[5*g +: 5];
        mOpId = g;
        mPtr = (g + 1) % 4;
        mPhase = 1;
      end
    end else if (mPhase <= Lat) begin
      if (mPhase == Lat) begin
        mResC = sumOf(mA, mB);
        mResId = 2'(mOpId);
      end
      mPhase++;
    end else if (resReady) mPhase = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic r, input logic [3:0] v, input logic [19:0] a,
                       input logic [19:0] b, input logic rr);
    applyStimulus(r, v, a, b, rr);
    checkOutput();
    advance();
  endtask

  task automatic drainToIdle();
    int n = 0;
    while (mPhase != 0 && n < 20) begin
      cycle(1'b0, 4'b0000, 20'd0, 20'd0, 1'b1);
      n++;
    end
    chk("drain bound", 32'(mPhase), 32'd0);
  endtask

  initial begin
    int grantIdx[$];
    int grantCyc[$];
    int gi, n;
    logic [5:0] heldC;
    logic [1:0] heldId;

    tbl[0] = '{1'b1, 4'hF, 20'hFFFFF, 20'hFFFFF, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 6'd0, 2'd0};
    tbl[1] = '{1'b0, 4'b0010, 20'(32'd3 << 5), 20'(32'd4 << 5), 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 6'd0, 2'd0};
    tbl[2] = '{1'b0, 4'b0000, 20'd0, 20'd0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 6'd0, 2'd0};
    tbl[3] = '{1'b0, 4'b0000, 20'd0, 20'd0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 6'd0, 2'd0};
    tbl[4] = '{1'b0, 4'b0000, 20'd0, 20'd0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 6'b000111, 2'd1};
    tbl[5] = '{1'b0, 4'b0001, 20'd1, 20'd2, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 6'b000111, 2'd1};

    rst = 1'b1; reqValid = '0; reqA = '0; reqB = '0; resReady = 1'b1;
    rst1 = 1'b1; reqValid1 = '0; reqA1 = '0; reqB1 = '0; resReady1 = 1'b1; addC1 = '0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();

    $display("[TB] single request vector table");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].valid, tbl[i].a, tbl[i].b, tbl[i].rr);
      checkOutput();
      chk($sformatf("tbl%0d req_ready", i), 32'(reqReady), 32'(tbl[i].expReady));
      chk($sformatf("tbl%0d add_go", i), 32'(addGo), 32'(tbl[i].expGo));
      chk($sformatf("tbl%0d busy", i), 32'(busy), 32'(tbl[i].expBusy));
      chk($sformatf("tbl%0d res_valid", i), 32'(resValid), 32'(tbl[i].expResValid));
      chk($sformatf("tbl%0d res_c", i), 32'(resC), 32'(tbl[i].expResC));
      chk($sformatf("tbl%0d res_id", i), 32'(resId), 32'(tbl[i].expResId));
      advance();
    end

    $display("[TB] round-robin fairness");
    for (int c = 0; c < 22; c++) begin
      applyStimulus(1'b0, 4'hF, 20'($urandom), 20'($urandom), 1'b1);
      if (reqReady != 4'b0000) begin
        grantIdx.push_back(oneHotIdx(reqReady));
        grantCyc.push_back(c);
      end
      checkOutput();
      advance();
    end
    chk("rr grant count", 32'(grantIdx.size()), 32'd5);
    chk("rr first grant", 32'(grantIdx.size() > 0 ? grantIdx[0] : -1), 32'd1);
    for (int i = 1; i < grantIdx.size(); i++) begin
      chk($sformatf("rr order %0d", i), 32'(grantIdx[i]), 32'((grantIdx[i-1] + 1) % 4));
      chk($sformatf("rr spacing %0d", i), 32'(grantCyc[i] - grantCyc[i-1]), 32'(Lat + 2));
    end

    $display("[TB] back-pressure");
    drainToIdle();
    cycle(1'b0, 4'b0100, 20'(32'd13 << 10), 20'(32'd9 << 10), 1'b0);
    n = 0;
    applyStimulus(1'b0, 4'hF, 20'($urandom), 20'($urandom), 1'b0);
    while (resValid !== 1'b1 && n < 10) begin
      checkOutput();
      advance();
      applyStimulus(1'b0, 4'hF, 20'($urandom), 20'($urandom), 1'b0);
      n++;
    end
    chk("bp res_valid seen", 32'(resValid), 32'd1);
    heldC = resC;
    heldId = resId;
    chk("bp captured c", 32'(heldC), 32'(6'd22));
    chk("bp captured id", 32'(heldId), 32'd2);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) applyStimulus(1'b0, 4'hF, 20'($urandom), 20'($urandom), 1'b0);
      checkOutput();
      chk("bp res_c stable", 32'(resC), 32'(heldC));
      chk("bp res_id stable", 32'(resId), 32'(heldId));
      chk("bp req_ready low", 32'(reqReady), 32'd0);
      advance();
    end
    cycle(1'b0, 4'hF, 20'd0, 20'd0, 1'b1);
    applyStimulus(1'b0, 4'hF, 20'd0, 20'd0, 1'b1);
    chk("bp regrant", 32'(reqReady), 32'(4'b1000));
    checkOutput();
    advance();

    $display("[TB] reset mid-busy");
    drainToIdle();
    cycle(1'b0, 4'b0001, 20'd7, 20'd5, 1'b1);
    cycle(1'b0, 4'b0000, 20'd0, 20'd0, 1'b1);
    cycle(1'b1, 4'b0000, 20'd0, 20'd0, 1'b1);
    applyStimulus(1'b0, 4'b1000, 20'(32'd6 << 15), 20'(32'd2 << 15), 1'b1);
    chk("rst res_valid", 32'(resValid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst add_a", 32'(addA), 32'd0);
    chk("rst add_b", 32'(addB), 32'd0);
    chk("rst regrant 3", 32'(reqReady), 32'(4'b1000));
    checkOutput();
    advance();
    for (int c = 0; c < 5; c++) cycle(1'b0, 4'b0000, 20'd0, 20'd0, 1'b1);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 400; c++) begin
      gi = int'($urandom_range(0, 3));
      cycle(($urandom_range(0, 63) == 0), (gi == 0) ? 4'b0000 : 4'($urandom),
            20'($urandom), 20'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("[TB] ADD_LAT=1 capture and operand hold");
    rst1 = 1'b0; reqValid1 = 4'b0001; reqA1 = 20'h0001F; reqB1 = 20'h0000F; resReady1 = 1'b1;
    @(negedge clk);
    chk("l1 c0 req_ready", 32'(reqReady1), 32'(4'b0001));
    @(posedge clk); #1;
    reqValid1 = 4'b0000; addC1 = 6'b011110;
    @(negedge clk);
    chk("l1 c1 add_go", 32'(addGo1), 32'd1);
    chk("l1 c1 busy", 32'(busy1), 32'd1);
    chk("l1 c1 add_a", 32'(addA1), 32'h1F);
    chk("l1 c1 add_b", 32'(addB1), 32'h0F);
    chk("l1 c1 res_valid", 32'(resValid1), 32'd0);
    @(posedge clk); #1;
    addC1 = 6'b010101; resReady1 = 1'b0;
    @(negedge clk);
    chk("l1 c2 res_valid", 32'(resValid1), 32'd1);
    chk("l1 c2 res_c", 32'(resC1), 32'(6'b011110));
    chk("l1 c2 res_id", 32'(resId1), 32'd0);
    chk("l1 c2 add_a", 32'(addA1), 32'h1F);
    @(posedge clk); #1;
    addC1 = 6'h3F; resReady1 = 1'b1;
    @(negedge clk);
    chk("l1 c3 res_valid", 32'(resValid1), 32'd1);
    chk("l1 c3 res_c", 32'(resC1), 32'(6'b011110));
    chk("l1 c3 add_b", 32'(addB1), 32'h0F);
    @(posedge clk); #1;
    @(negedge clk);
    chk("l1 c4 busy", 32'(busy1), 32'd0);
    chk("l1 c4 res_valid", 32'(resValid1), 32'd0);
    chk("l1 c4 add_a", 32'(addA1), 32'h1F);
    chk("l1 c4 add_b", 32'(addB1), 32'h0F);
    @(posedge clk); #1;
    reqValid1 = 4'b0100; reqA1 = 20'(32'd5 << 10); reqB1 = 20'(32'd9 << 10);
    @(negedge clk);
    chk("l1 c5 req_ready", 32'(reqReady1), 32'(4'b0100));
    chk("l1 c5 add_a", 32'(addA1), 32'h1F);
    @(posedge clk); #1;
    reqValid1 = 4'b0000;
    @(negedge clk);
    chk("l1 c6 add_a", 32'(addA1), 32'd5);
    chk("l1 c6 add_b", 32'(addB1), 32'd9);
    chk("l1 c6 add_go", 32'(addGo1), 32'd1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
